// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the round-robin register bank controller.
package regbank_pkg;

   localparam int RB_DEF_NREQ  = 4;
   localparam int RB_DEF_WIDTH = 8;
   localparam int RB_DEF_DEPTH = 4;
   localparam int RB_RST_DATA  = 0;

   // Never returns less than 1, so single-entry indices still get a real bit.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection with a registered priority pointer.
// REGBANK_LOCK_EN adds a lock input that lets the last winner keep ownership.
module rr_arbiter
   import regbank_pkg::*;
#(
   parameter int NREQ = RB_DEF_NREQ,
   parameter int IW   = clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
`ifdef REGBANK_LOCK_EN
   input  logic [NREQ-1:0] lock,
`endif
   output logic [IW-1:0]   win,
   output logic            valid
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] rr_win;
   logic          rr_valid;

   // Scan upward from the slot after the last winner, wrapping at NREQ.
   always_comb begin
      rr_win   = '0;
      rr_valid = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % NREQ;
         if (!rr_valid && req[idx]) begin
            rr_valid = 1'b1;
            rr_win   = IW'(idx);
         end
      end
   end

`ifdef REGBANK_LOCK_EN
   logic          locked;
   logic [IW-1:0] owner;

   always_comb begin
      win   = rr_win;
      valid = rr_valid;
      if (locked && req[owner] && lock[owner]) begin
         win   = owner;
         valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         locked <= 1'b0;
         owner  <= '0;
      end else begin
         locked <= valid && lock[win];
         owner  <= win;
      end
   end
`else
   always_comb begin
      win   = rr_win;
      valid = rr_valid;
   end
`endif

   // While locked the winner equals ptr, so ptr stays put without a special case.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= IW'(NREQ - 1);
      end else if (valid) begin
         ptr <= win;
      end
   end

endmodule

// File: rtl/regbank_rr_arbiter.sv
// Register bank shared by NREQ requesters through a round-robin arbiter.
// Define REGBANK_LOCK_EN to add the per-requester lock input.
module regbank_rr_arbiter
   import regbank_pkg::*;
#(
   parameter int NREQ  = RB_DEF_NREQ,
   parameter int WIDTH = RB_DEF_WIDTH,
   parameter int DEPTH = RB_DEF_DEPTH,
   parameter int AW    = clog2(DEPTH),
   parameter int IW    = clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       we,
   input  logic [NREQ*AW-1:0]    addr,
   input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef REGBANK_LOCK_EN
   input  logic [NREQ-1:0]       lock,
`endif
   output logic [NREQ-1:0]       gnt,
   output logic                  ack,
   output logic [WIDTH-1:0]      rdata,
   output logic [IW-1:0]         rd_id
);

   logic [WIDTH-1:0] bank [DEPTH];
   logic [IW-1:0]    win;
   logic             valid;
   logic [AW-1:0]    sel_addr;
   logic [WIDTH-1:0] sel_wdata;
   logic             sel_we;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
`ifdef REGBANK_LOCK_EN
      .lock  (lock),
`endif
      .win   (win),
      .valid (valid)
   );

   always_comb begin
      sel_addr  = addr[win*AW +: AW];
      sel_wdata = wdata[win*WIDTH +: WIDTH];
      sel_we    = we[win];
   end

   // rdata samples the bank before the winner's write lands on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) bank[i] <= WIDTH'(RB_RST_DATA);
         gnt   <= '0;
         ack   <= 1'b0;
         rdata <= WIDTH'(RB_RST_DATA);
         rd_id <= '0;
      end else if (valid) begin
         gnt   <= NREQ'(1) << win;
         ack   <= 1'b1;
         rdata <= bank[sel_addr];
         rd_id <= win;
         if (sel_we) bank[sel_addr] <= sel_wdata;
      end else begin
         gnt <= '0;
         ack <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
// Directed self-checking bench for regbank_rr_arbiter (4 requesters, 8-bit, 4 deep).
// Lock scenarios run only when REGBANK_LOCK_EN is defined.
module tb_regbank_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  we;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic        ack;
   logic [7:0]  rdata;
   logic [1:0]  rd_id;
`ifdef REGBANK_LOCK_EN
   logic [3:0]  lock;
`endif

   int errors;
   int checks;

   regbank_rr_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
`ifdef REGBANK_LOCK_EN
      .lock  (lock),
`endif
      .gnt   (gnt),
      .ack   (ack),
      .rdata (rdata),
      .rd_id (rd_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w,
                                input logic [7:0] a, input logic [31:0] d);
      req   = r;
      we    = w;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic checkGrant(input string tag, input logic [3:0] eg, input logic ea,
                             input logic [7:0] ed, input logic [1:0] ei);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'(eg));
      checkOutput({tag, "_ack"}, 32'(ack), 32'(ea));
      checkOutput({tag, "_rdata"}, 32'(rdata), 32'(ed));
      checkOutput({tag, "_rd_id"}, 32'(rd_id), 32'(ei));
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
`ifdef REGBANK_LOCK_EN
      lock   = 4'b0000;
`endif
      applyStimulus(4'b0000, 4'b0000, 8'h00, 32'h0);
      applyStimulus(4'b0000, 4'b0000, 8'h00, 32'h0);
      checkGrant("reset", 4'b0000, 1'b0, 8'h00, 2'd0);

      rst_n = 1'b1;
      applyStimulus(4'b0000, 4'b0000, 8'h00, 32'h0);
      checkGrant("idle_after_reset", 4'b0000, 1'b0, 8'h00, 2'd0);

      // Requester 0 reads every address; all must be cleared.
      applyStimulus(4'b0001, 4'b0000, 8'h00, 32'h0);
      checkGrant("rd_addr0", 4'b0001, 1'b1, 8'h00, 2'd0);
      applyStimulus(4'b0001, 4'b0000, 8'h01, 32'h0);
      checkGrant("rd_addr1", 4'b0001, 1'b1, 8'h00, 2'd0);
      applyStimulus(4'b0001, 4'b0000, 8'h02, 32'h0);
      checkGrant("rd_addr2", 4'b0001, 1'b1, 8'h00, 2'd0);
      applyStimulus(4'b0001, 4'b0000, 8'h03, 32'h0);
      checkGrant("rd_addr3", 4'b0001, 1'b1, 8'h00, 2'd0);

      // Requester 2 writes 0xA5 to addr 1, then reads it back.
      applyStimulus(4'b0100, 4'b0100, 8'h10, 32'h00A5_0000);
      checkGrant("wr2", 4'b0100, 1'b1, 8'h00, 2'd2);
      applyStimulus(4'b0100, 4'b0000, 8'h10, 32'h0);
      checkGrant("rd2", 4'b0100, 1'b1, 8'hA5, 2'd2);

      // Park ptr at 3, then full contention reading addr 1.
      applyStimulus(4'b1000, 4'b0000, 8'h55, 32'h0);
      checkGrant("park3", 4'b1000, 1'b1, 8'hA5, 2'd3);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(4'b1111, 4'b0000, 8'h55, 32'h0);
         checkGrant($sformatf("contend%0d", i), 4'(1 << (i % 4)), 1'b1, 8'hA5, 2'(i % 4));
      end

      // ptr is 3: search wraps to 0, so 1 wins before 3.
      applyStimulus(4'b1010, 4'b0000, 8'h55, 32'h0);
      checkGrant("wrap_a", 4'b0010, 1'b1, 8'hA5, 2'd1);
      applyStimulus(4'b1010, 4'b0000, 8'h55, 32'h0);
      checkGrant("wrap_b", 4'b1000, 1'b1, 8'hA5, 2'd3);

      // Write by requester 3, read by requester 0 on the next cycle.
      applyStimulus(4'b1000, 4'b1000, 8'hC0, 32'h5A00_0000);
      checkGrant("wr3", 4'b1000, 1'b1, 8'h00, 2'd3);
      applyStimulus(4'b0001, 4'b0000, 8'h03, 32'h0);
      checkGrant("rd3_by0", 4'b0001, 1'b1, 8'h5A, 2'd0);

      applyStimulus(4'b0000, 4'b0000, 8'h00, 32'h0);
      checkGrant("idle_hold", 4'b0000, 1'b0, 8'h5A, 2'd0);

      // Requesters 0 and 1 both write addr 2; ptr=0 so only requester 1 lands.
      applyStimulus(4'b0011, 4'b0011, 8'h0A, 32'h0000_2211);
      checkGrant("collide", 4'b0010, 1'b1, 8'h00, 2'd1);
      applyStimulus(4'b0001, 4'b0000, 8'h02, 32'h0);
      checkGrant("collide_rd", 4'b0001, 1'b1, 8'h22, 2'd0);

      // Write attempted on the same edge as reset must be dropped.
      rst_n = 1'b0;
      applyStimulus(4'b0001, 4'b0001, 8'h02, 32'h0000_003C);
      checkGrant("rst_mid_wr", 4'b0000, 1'b0, 8'h00, 2'd0);
      rst_n = 1'b1;
      applyStimulus(4'b0001, 4'b0000, 8'h02, 32'h0);
      checkGrant("rst_mid_rd", 4'b0001, 1'b1, 8'h00, 2'd0);

`ifdef REGBANK_LOCK_EN
      // ptr=0: requester 1 wins, then keeps the bank while locked.
      lock = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b1111, 4'b0000, 8'h00, 32'h0);
         checkGrant($sformatf("lock%0d", i), 4'b0010, 1'b1, 8'h00, 2'd1);
      end
      lock = 4'b0000;
      applyStimulus(4'b1111, 4'b0000, 8'h00, 32'h0);
      checkGrant("unlock", 4'b0100, 1'b1, 8'h00, 2'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regbank_rr_arbiter.md
Name: regbank_rr_arbiter

Overview:
- Round-robin arbiter and controller for a shared register bank of DEPTH x WIDTH D flip-flops.
- Up to NREQ requesters contend for single-port access; one read-or-write access is granted per cycle.
- Each access returns read data and a one-hot grant tag.
- Sits between requester datapaths and the flip-flop storage, which is instantiated inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data bits per register.
- DEPTH, 4, number of registers (power of two). AW = log2(DEPTH), minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- req  in  NREQ  per-requester access request, level.
- we  in  NREQ  per-requester write enable: 1 = write, 0 = read. Qualified by req.
- addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- wdata  in  NREQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  registered one-hot grant, or all-zero.
- ack  out  1  registered; high when an access completed on the previous edge.
- rdata  out  WIDTH  registered; register contents at the granted addr before any write (read-before-write).
- rd_id  out  log2(NREQ)  binary index of the granted requester.

Behaviour:
- Reset, applied while rst_n=0 at a clk edge:
  - gnt=0, ack=0, rdata=0, rd_id=0.
  - All bank registers cleared to 0.
  - Round-robin pointer ptr = NREQ-1, so requester 0 has highest priority first.
  - Reset mid-access aborts it: no write occurs on that edge.
- Arbitration in cycle T:
  - Search req starting at index (ptr+1) mod NREQ, wrapping upward.
  - The first asserted index is the winner w. The search is combinational.
- At edge T+1, if a winner exists:
  - gnt = onehot(w), rd_id = w, ack = 1.
  - rdata = bank[addr_w] as it was before the edge.
  - If we[w]=1: bank[addr_w] = wdata_w.
  - ptr = w.
- At edge T+1, if no req is asserted: gnt=0, ack=0, rdata and rd_id hold, ptr holds.
- Latency: exactly 1 cycle from req sampled to gnt/ack/rdata valid.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees its gnt bit.
  - It must deassert req in the cycle gnt is seen, unless it wants another access.
  - A req still high in the gnt cycle is arbitrated as a new request. Because ptr has moved, it gets lowest priority.
- Fairness: with all NREQ requesting continuously, each is granted exactly once per NREQ cycles.
- Single requester: granted every cycle (back-to-back) while req is held.
- Same-cycle events: losers receive no side effect; only the winner's write lands.
- A write followed by a read of the same address in the next cycle returns the new value.
- Address width: addr is exactly AW bits, so out-of-range addresses are impossible.
- Pointer wrap: after ptr=NREQ-1, the search starts at 0.

Optional Feature:
- Macro: REGBANK_LOCK_EN.
- With the macro defined:
  - Adds input lock [NREQ].
  - If the winner at edge T+1 had lock[w]=1 and still asserts req and lock in the next cycle, it wins again regardless of round-robin order.
  - ptr is not advanced while locked.
  - Dropping lock or req releases ownership; normal round-robin resumes from ptr=w.
- Without the macro: no lock port; pure round-robin.

Decomposition:
- Package regbank_pkg:
  - Default constants for NREQ, WIDTH, DEPTH.
  - A clog2 function for deriving AW and the rd_id width.
  - Reset value constant RB_RST_DATA = 0.
- Sub-module rr_arbiter:
  - Owns ptr and the wrap-around priority search, plus lock hold when REGBANK_LOCK_EN is defined.
  - Outputs the winner index and a valid flag.
- Top block owns the bank registers, the rdata/gnt/ack/rd_id registers and the operand mux.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release. Expect gnt=0, ack=0, rdata=0, and reads of all 4 addresses return 0.
- Single write/read: requester 2 writes addr=1, wdata=0xA5, then reads addr=1 next cycle. Expect gnt=4'b0100 and ack=1 each cycle; read rdata=0xA5, rd_id=2.
- Full contention: req=4'b1111 held for 8 cycles, all reads. Expect gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
- Priority after wrap: ptr=3 via a grant to requester 3, then req=4'b1010. Expect gnt=4'b0010 first, then 4'b1000.
- Reset mid-write: requester 0 writes addr=2, wdata=0x3C, with rst_n=0 at the same edge. Expect bank[2]=0 afterwards and ack=0.
- Lock (REGBANK_LOCK_EN): requester 1 holds req+lock for 3 cycles while req=4'b1111. Expect gnt=4'b0010 for 3 consecutive cycles; after lock drops, next gnt=4'b0100.
